video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_pkg.sv | 53 +++++
 rtl/test_pattern_gen.sv | 41 ++++
 rtl/video_timing_gen.sv | 135 +++++++++++++
 tb/tb_video_timing_gen.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing defaults, pattern codes and pixel types for the
// video timing generator and the HDMI top that consumes it.
package video_timing_pkg;

  localparam int unsigned CNT_W    = 12;
  localparam int unsigned COMP_W   = 8;
  localparam int unsigned RGB_W    = 3 * COMP_W;
  localparam int unsigned PAT_W    = 2;
  localparam int unsigned NUM_BARS = 8;
  localparam int unsigned CELL_BIT = 5;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;

  typedef enum logic [PAT_W-1:0] {
    PAT_BARS     = 2'd0,
    PAT_SOLID    = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_CHECKER  = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_WHITE = rgb_t'(24'hFFFFFF);
  localparam rgb_t RGB_BLACK = rgb_t'(24'h000000);

  // Bar order left to right: white, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb_t bar_color(input logic [2:0] idx);
    logic [2:0] on;
    case (idx)
      3'd0:    on = 3'b111;
      3'd1:    on = 3'b110;
      3'd2:    on = 3'b011;
      3'd3:    on = 3'b010;
      3'd4:    on = 3'b101;
      3'd5:    on = 3'b100;
      3'd6:    on = 3'b001;
      default: on = 3'b000;
    endcase
    return '{r: {COMP_W{on[2]}}, g: {COMP_W{on[1]}}, b: {COMP_W{on[0]}}};
  endfunction

endpackage

// File: rtl/test_pattern_gen.sv
// Combinational test-pattern colour lookup for one pixel coordinate.
// Output is meaningful only inside the active region; the caller blanks it.
module test_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  pattern_e         pattern,
  input  logic [RGB_W-1:0] solidColor,
  output rgb_t             rgb
);

  localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;

  logic [2:0] w_bar_idx;
  logic       w_unused_y;

  // Threshold compare instead of a divider; the last bar keeps any remainder
  always_comb begin
    w_bar_idx = 3'd0;
    for (int unsigned k = 1; k < NUM_BARS; k++) begin
      if (x >= CNT_W'(k * BAR_W)) w_bar_idx = 3'(k);
    end
  end

  always_comb begin
    rgb = RGB_BLACK;
    case (pattern)
      PAT_BARS:     rgb = bar_color(w_bar_idx);
      PAT_SOLID:    rgb = rgb_t'(solidColor);
      PAT_GRADIENT: rgb = '{r: x[COMP_W-1:0], g: x[COMP_W-1:0], b: x[COMP_W-1:0]};
      PAT_CHECKER:  rgb = (x[CELL_BIT] ^ y[CELL_BIT]) ? RGB_BLACK : RGB_WHITE;
      default:      rgb = RGB_BLACK;
    endcase
  end

  assign w_unused_y = ^{y[CNT_W-1:CELL_BIT+1], y[CELL_BIT-1:0]};

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, syncs, display enable, coordinates
// and a frame-synchronous test pattern, all registered one cycle after the counters.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT         = H_FRONT_DEF,
  parameter int unsigned H_SYNC          = H_SYNC_DEF,
  parameter int unsigned H_BACK          = H_BACK_DEF,
  parameter int unsigned V_ACTIVE        = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT         = V_FRONT_DEF,
  parameter int unsigned V_SYNC          = V_SYNC_DEF,
  parameter int unsigned V_BACK          = V_BACK_DEF,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              pixelClock,
  input  logic              resetN,
  input  logic [PAT_W-1:0]  patternSelect,
  input  logic [RGB_W-1:0]  solidColor,
  output logic              DE,
  output logic              hsync,
  output logic              vsync,
  output logic [COMP_W-1:0] red,
  output logic [COMP_W-1:0] green,
  output logic [COMP_W-1:0] blue,
  output logic [CNT_W-1:0]  pixelX,
  output logic [CNT_W-1:0]  pixelY,
  output logic              frameStart
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;
  pattern_e         r_pattern;
  logic [RGB_W-1:0] r_solid;

  logic             r_de;
  logic             r_hsync;
  logic             r_vsync;
  rgb_t             r_rgb;
  logic [CNT_W-1:0] r_pixel_x;
  logic [CNT_W-1:0] r_pixel_y;
  logic             r_frame_start;

  logic             w_h_last;
  logic             w_v_last;
  logic             w_active;
  logic             w_hsync_on;
  logic             w_vsync_on;
  rgb_t             w_pattern_rgb;

  assign w_h_last   = (r_h_count == H_LAST_C);
  assign w_v_last   = (r_v_count == V_LAST_C);
  assign w_active   = (r_h_count < H_ACT_C) && (r_v_count < V_ACT_C);
  assign w_hsync_on = (r_h_count >= HS_START_C) && (r_h_count < HS_END_C);
  // v only moves on the h wrap, so vsync edges land on hCount=0
  assign w_vsync_on = (r_v_count >= VS_START_C) && (r_v_count < VS_END_C);

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_h_last) begin
      r_h_count <= '0;
      r_v_count <= w_v_last ? '0 : r_v_count + CNT_W'(1);
    end else begin
      r_h_count <= r_h_count + CNT_W'(1);
    end
  end

  // Pattern controls only change at the last pixel of a frame
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      r_pattern <= PAT_BARS;
      r_solid   <= '0;
    end else if (w_h_last && w_v_last) begin
      r_pattern <= pattern_e'(patternSelect);
      r_solid   <= solidColor;
    end
  end

  test_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .x          (r_h_count),
    .y          (r_v_count),
    .pattern    (r_pattern),
    .solidColor (r_solid),
    .rgb        (w_pattern_rgb)
  );

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      r_de          <= 1'b0;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_rgb         <= RGB_BLACK;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_de          <= w_active;
      r_hsync       <= w_hsync_on ^ SYNC_IDLE;
      r_vsync       <= w_vsync_on ^ SYNC_IDLE;
      r_rgb         <= w_active ? w_pattern_rgb : RGB_BLACK;
      r_pixel_x     <= r_h_count;
      r_pixel_y     <= r_v_count;
      r_frame_start <= (r_h_count == '0) && (r_v_count == '0);
    end
  end

  assign DE         = r_de;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign red        = r_rgb.r;
  assign green      = r_rgb.g;
  assign blue       = r_rgb.b;
  assign pixelX     = r_pixel_x;
  assign pixelY     = r_pixel_y;
  assign frameStart = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster so several frames fit in a short run.
module tb_video_timing_gen;

  localparam int HA = 67, HF = 5, HS = 7, HB = 6;
  localparam int VA = 40, VF = 3, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        pixelClock = 1'b0;
  logic        resetN = 1'b0;
  logic [1:0]  patternSelect = 2'd0;
  logic [23:0] solidColor = 24'h0;
  logic        DE, hsync, vsync, frameStart;
  logic [7:0]  red, green, blue;
  logic [11:0] pixelX, pixelY;

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .pixelClock    (pixelClock),
    .resetN        (resetN),
    .patternSelect (patternSelect),
    .solidColor    (solidColor),
    .DE            (DE),
    .hsync         (hsync),
    .vsync         (vsync),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .pixelX        (pixelX),
    .pixelY        (pixelY),
    .frameStart    (frameStart)
  );

  always #5 pixelClock = ~pixelClock;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } obs_t;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          m_h, m_v;
  logic [1:0]  m_pat;
  logic [23:0] m_solid;

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reference outputs for counter state (h,v) under the given shadow pattern
  function automatic obs_t model_out(input int h, input int v, input logic [1:0] pat,
                                     input logic [23:0] solid);
    obs_t o;
    int   idx;
    o.de  = (h < HA) && (v < VA);
    o.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    o.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    o.x   = 12'(h);
    o.y   = 12'(v);
    o.fs  = (h == 0) && (v == 0);
    o.rgb = 24'h0;
    if (o.de) begin
      case (pat)
        2'd0: begin
          idx = h / (HA / 8);
          if (idx > 7) idx = 7;
          o.rgb = bar_rgb(idx);
        end
        2'd1: o.rgb = solid;
        2'd2: o.rgb = {3{8'(h)}};
        default: o.rgb = (((h / 32) + (v / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      endcase
    end
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.de  = DE;
    o.hs  = hsync;
    o.vs  = vsync;
    o.rgb = {red, green, blue};
    o.x   = pixelX;
    o.y   = pixelY;
    o.fs  = frameStart;
    return o;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_pat = 2'd0; m_solid = 24'h0;
  endtask

  // One clock: push the expected output, let the DUT register it, pop and compare
  task automatic step();
    obs_t e, a;
    exp_q.push_back(model_out(m_h, m_v, m_pat, m_solid));
    @(posedge pixelClock);
    #1;
    e = exp_q.pop_front();
    a = sample_dut();
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL scoreboard h=%0d v=%0d: got %h expected %h", m_h, m_v, a, e);
    end
    if (m_h == HT - 1 && m_v == VT - 1) begin
      m_pat = patternSelect;
      m_solid = solidColor;
    end
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
  endtask

  task automatic wait_xy(input int x, input int y);
    int n;
    n = 0;
    while (!(pixelX == 12'(x) && pixelY == 12'(y)) && n < 2 * FRAME) begin
      step();
      n++;
    end
    n_checks++;
    if (pixelX !== 12'(x) || pixelY !== 12'(y)) begin
      n_err++;
      $display("FAIL wait_xy: at x=%0d y=%0d, required x=%0d y=%0d", pixelX, pixelY, x, y);
    end
  endtask

  task automatic test_reset();
    obs_t a;
    resetN = 1'b0;
    repeat (3) begin
      @(posedge pixelClock);
      #1;
      a = sample_dut();
      n_checks++;
      if (a !== reset_obs()) begin
        n_err++;
        $display("FAIL reset_hold: got %h expected %h", a, reset_obs());
      end
    end
    @(negedge pixelClock);
    resetN = 1'b1;
    model_reset();
    step();
    n_checks++;
    if ({DE, frameStart, pixelX, pixelY} !== {1'b1, 1'b1, 12'd0, 12'd0}) begin
      n_err++;
      $display("FAIL reset_release: DE=%b fs=%b x=%0d y=%0d, required 1 1 0 0",
               DE, frameStart, pixelX, pixelY);
    end
  endtask

  task automatic test_line();
    int cnt, de_cnt, hs_cnt, hs_first;
    wait_xy(0, 1);
    cnt = 0; de_cnt = 0; hs_cnt = 0; hs_first = -1;
    do begin
      if (DE) de_cnt++;
      if (!hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(pixelX);
      end
      cnt++;
      step();
    end while (pixelX != 12'd0 && cnt < 2 * HT);
    n_checks++;
    if (cnt != HT) begin n_err++; $display("FAIL line_period: got %0d required %0d", cnt, HT); end
    n_checks++;
    if (de_cnt != HA) begin n_err++; $display("FAIL line_de: got %0d required %0d", de_cnt, HA); end
    n_checks++;
    if (hs_cnt != HS) begin n_err++; $display("FAIL line_hsync_len: got %0d required %0d", hs_cnt, HS); end
    n_checks++;
    if (hs_first != HA + HF) begin
      n_err++;
      $display("FAIL line_hsync_start: got %0d required %0d", hs_first, HA + HF);
    end
  endtask

  task automatic test_frame();
    int   cnt, de_cnt, hs_cnt, vs_cnt, vs_out, edges, bad_edges, blank_rgb;
    logic prev_vs;
    wait_xy(0, 0);
    cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_out = 0;
    edges = 0; bad_edges = 0; blank_rgb = 0; prev_vs = vsync;
    do begin
      if (DE) de_cnt++;
      else if ({red, green, blue} != 24'h0) blank_rgb++;
      if (!hsync) hs_cnt++;
      if (!vsync) begin
        vs_cnt++;
        if (int'(pixelY) < VA + VF || int'(pixelY) >= VA + VF + VS) vs_out++;
      end
      if (vsync != prev_vs) begin
        edges++;
        if (pixelX != 12'd0) bad_edges++;
      end
      prev_vs = vsync;
      cnt++;
      step();
    end while (!frameStart && cnt < 2 * FRAME);
    n_checks++;
    if (cnt != FRAME) begin n_err++; $display("FAIL frame_period: got %0d required %0d", cnt, FRAME); end
    n_checks++;
    if (de_cnt != HA * VA) begin n_err++; $display("FAIL frame_de: got %0d required %0d", de_cnt, HA * VA); end
    n_checks++;
    if (hs_cnt != HS * VT) begin n_err++; $display("FAIL frame_hsync: got %0d required %0d", hs_cnt, HS * VT); end
    n_checks++;
    if (vs_cnt != VS * HT) begin n_err++; $display("FAIL frame_vsync_len: got %0d required %0d", vs_cnt, VS * HT); end
    n_checks++;
    if (vs_out != 0) begin n_err++; $display("FAIL frame_vsync_lines: got %0d stray required 0", vs_out); end
    n_checks++;
    if (edges != 2 || bad_edges != 0) begin
      n_err++;
      $display("FAIL frame_vsync_edges: got %0d edges %0d off x=0, required 2 and 0", edges, bad_edges);
    end
    n_checks++;
    if (blank_rgb != 0) begin n_err++; $display("FAIL frame_blank_rgb: got %0d nonzero required 0", blank_rgb); end
  endtask

  task automatic test_bars();
    int          xs [7] = '{0, 7, 8, 16, 55, 56, 66};
    logic [24:0] req [7] = '{25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFF00, 25'h100FFFF,
                             25'h10000FF, 25'h1000000, 25'h1000000};
    for (int i = 0; i < 7; i++) begin
      wait_xy(xs[i], 5);
      n_checks++;
      if ({DE, red, green, blue} !== req[i]) begin
        n_err++;
        $display("FAIL bars_x%0d: got DE/rgb %h required %h", xs[i], {DE, red, green, blue}, req[i]);
      end
    end
    wait_xy(HA, 5);
    n_checks++;
    if ({DE, red, green, blue} !== 25'h0) begin
      n_err++;
      $display("FAIL bars_blank: got DE/rgb %h required 0", {DE, red, green, blue});
    end
  endtask

  task automatic test_pattern_switch();
    int cnt, act, bad;
    wait_xy(0, 10);
    patternSelect = 2'd1;
    solidColor = 24'h123456;
    wait_xy(8, 20);
    n_checks++;
    if ({red, green, blue} !== 24'hFFFF00) begin
      n_err++;
      $display("FAIL switch_same_frame: got %h required ffff00", {red, green, blue});
    end
    wait_xy(60, VA - 1);
    n_checks++;
    if ({DE, red, green, blue} !== 25'h1000000) begin
      n_err++;
      $display("FAIL switch_last_bar: got DE/rgb %h required 1000000", {DE, red, green, blue});
    end
    wait_xy(0, 0);
    cnt = 0; act = 0; bad = 0;
    do begin
      if (DE) begin
        act++;
        if ({red, green, blue} != 24'h123456) bad++;
      end
      cnt++;
      step();
    end while (!frameStart && cnt < 2 * FRAME);
    n_checks++;
    if (act != HA * VA || bad != 0) begin
      n_err++;
      $display("FAIL switch_solid_frame: got %0d active %0d wrong, required %0d and 0", act, bad, HA * VA);
    end
  endtask

  task automatic test_gradient();
    int          xs [3] = '{37, 66, 5};
    int          ys [3] = '{3, VA - 1, 3};
    logic [23:0] req [3] = '{24'h252525, 24'h424242, 24'h050505};
    wait_xy(0, 10);
    patternSelect = 2'd2;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) wait_xy(0, 0);
      wait_xy(xs[i], ys[i]);
      n_checks++;
      if ({red, green, blue} !== req[i]) begin
        n_err++;
        $display("FAIL gradient_x%0d_y%0d: got %h required %h", xs[i], ys[i], {red, green, blue}, req[i]);
      end
    end
  endtask

  task automatic test_checker();
    int          xs [4] = '{10, 40, 10, 40};
    int          ys [4] = '{3, 3, 33, 33};
    logic [23:0] req [4] = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};
    wait_xy(0, 10);
    patternSelect = 2'd3;
    for (int i = 0; i < 4; i++) begin
      wait_xy(xs[i], ys[i]);
      n_checks++;
      if ({DE, red, green, blue} !== {1'b1, req[i]}) begin
        n_err++;
        $display("FAIL checker_x%0d_y%0d: got DE/rgb %h required %h", xs[i], ys[i],
                 {DE, red, green, blue}, {1'b1, req[i]});
      end
    end
  endtask

  task automatic test_midframe_reset();
    obs_t a;
    wait_xy(20, 30);
    #2;
    resetN = 1'b0;
    #1;
    a = sample_dut();
    n_checks++;
    if (a !== reset_obs()) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", a, reset_obs());
    end
    @(posedge pixelClock);
    #1;
    a = sample_dut();
    n_checks++;
    if (a !== reset_obs()) begin
      n_err++;
      $display("FAIL reset_held: got %h expected %h", a, reset_obs());
    end
    @(negedge pixelClock);
    resetN = 1'b1;
    model_reset();
    step();
    n_checks++;
    if ({frameStart, DE, pixelX, pixelY, red, green, blue} !== {2'b11, 24'd0, 24'hFFFFFF}) begin
      n_err++;
      $display("FAIL restart: fs=%b DE=%b x=%0d y=%0d rgb=%h, required 1 1 0 0 ffffff",
               frameStart, DE, pixelX, pixelY, {red, green, blue});
    end
    repeat (2 * HT) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_line();
    test_frame();
    test_bars();
    test_pattern_switch();
    test_gradient();
    test_checker();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
